sram_burst_master: RTL and testbench

- Initiator side of the 64 kB single-port SRAM macro wrapper (CK/CS/OE/WEB[3:0]/A[13:0]/DI/DO).
- Accepts burst read/write commands from an accelerator or DMA front-end and drives the SRAM pins.
- Write data is consumed from a valid/ready stream; read data is returned on a valid/ready stream through a small FIFO.
- Sits between the face-detection datapath and one SRAM_64k instance.

---
 rtl/sram_burst_master_if.sv | 40 ++++
 rtl/sram_burst_master.sv | 157 +++++++++++++++
 tb/tb_sram_burst_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_master_if.sv
// Command, write-data, read-return and SRAM pin bundle for sram_burst_master.
// The master modport is the burst master's own view; slave is the front-end/SRAM side.
interface sram_burst_master_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [13:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0]       cmd_wstrb;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [31:0]      wdata;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [31:0]      rdata;
    logic             rdata_last;
    logic             done;
    logic             sram_cs;
    logic             sram_oe;
    logic [3:0]       sram_web;
    logic [13:0]      sram_a;
    logic [31:0]      sram_di;
    logic [31:0]      sram_do;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wstrb,
        input  wdata_valid, wdata, rdata_ready, sram_do,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
        output sram_cs, sram_oe, sram_web, sram_a, sram_di
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wstrb,
        output wdata_valid, wdata, rdata_ready, sram_do,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
        input  sram_cs, sram_oe, sram_web, sram_a, sram_di
    );
endinterface

// File: rtl/sram_burst_master.sv
// Burst read/write master for a 64 kB single-port SRAM with a small read-return FIFO.
// Define SRAM_BURST_MASTER_PERF_EN to add the saturating perf_beats/perf_stall counters.
module sram_burst_master #(
    parameter int RD_FIFO_DEPTH = 4,
    parameter int LEN_W         = 8
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef SRAM_BURST_MASTER_PERF_EN
    output logic [31:0] perf_beats,
    output logic [31:0] perf_stall,
`endif
    sram_burst_master_if.master bus
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t           state;
    logic [13:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [3:0]       wstrb_q;
    logic             rd_pend;
    logic             pend_last;
    logic             done_q;
    logic [13:0]      a_hold;
    logic [31:0]      di_hold;

    logic [32:0]      fifo_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic last_beat, wr_fire, rd_issue, cs, fifo_push, fifo_pop;

    assign last_beat = (beat_cnt == len_q);
    assign wr_fire   = (state == WRITE) && bus.wdata_valid;
    // Reserve a FIFO slot for the beat still in flight inside the SRAM.
    assign rd_issue  = (state == READ) && ((int'(fifo_count) + int'(rd_pend)) < RD_FIFO_DEPTH);
    assign cs        = wr_fire || rd_issue;
    assign fifo_push = rd_pend;
    assign fifo_pop  = bus.rdata_valid && bus.rdata_ready;

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.wdata_ready = (state == WRITE);
    assign bus.done        = done_q;
    assign bus.sram_cs     = cs;
    assign bus.sram_oe     = rd_pend;
    assign bus.sram_web    = wr_fire ? ~wstrb_q : 4'hF;
    // Address and data pins hold their last value between accesses.
    assign bus.sram_a      = cs ? addr_q : a_hold;
    assign bus.sram_di     = wr_fire ? bus.wdata : di_hold;
    assign bus.rdata_valid = (fifo_count != '0);
    assign bus.rdata       = bus.rdata_valid ? fifo_mem[rd_ptr][31:0] : 32'd0;
    assign bus.rdata_last  = bus.rdata_valid && fifo_mem[rd_ptr][32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            wstrb_q   <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            done_q    <= 1'b0;
            a_hold    <= '0;
            di_hold   <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_pend   <= rd_issue;
            pend_last <= rd_issue && last_beat;
            if (cs)
                a_hold <= addr_q;
            if (wr_fire)
                di_hold <= bus.wdata;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q   <= bus.cmd_addr;
                        len_q    <= bus.cmd_len;
                        wstrb_q  <= bus.cmd_wstrb;
                        beat_cnt <= '0;
                        state    <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr_q   <= addr_q + 14'd1;
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_q   <= addr_q + 14'd1;
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_pend && pend_last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (fifo_push && !fifo_pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (fifo_pop && !fifo_push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= {pend_last, bus.sram_do};
    end

`ifdef SRAM_BURST_MASTER_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (cs)
                perf_beats <= sat_inc(perf_beats);
            if ((state == READ) && !rd_issue)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif
endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master: directed vector table, randomized bursts,
// an SRAM behavioural model and a word-level reference memory.
module tb_sram_burst_master;
    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sram_burst_master_if #(.LEN_W(LEN_W)) bus ();

`ifdef SRAM_BURST_MASTER_PERF_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_stall;
`endif

    sram_burst_master #(.RD_FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef SRAM_BURST_MASTER_PERF_EN
        .perf_beats (perf_beats),
        .perf_stall (perf_stall),
`endif
        .bus        (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC3A5_0000 ^ 32'(i) ^ (32'(i) << 17);
    endfunction

    // SRAM model: stores the difference from the power-up pattern so it starts defined.
    bit [31:0] sram_delta [16384];
    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_web == 4'hF) begin
                bus.sram_do <= sram_delta[bus.sram_a] ^ init_word(int'(bus.sram_a));
            end else begin
                logic [31:0] w;
                w = sram_delta[bus.sram_a] ^ init_word(int'(bus.sram_a));
                for (int b = 0; b < 4; b++)
                    if (!bus.sram_web[b]) w[8*b +: 8] = bus.sram_di[8*b +: 8];
                sram_delta[bus.sram_a] <= w ^ init_word(int'(bus.sram_a));
            end
        end
    end

    typedef struct {
        logic [13:0] a;
        logic [3:0]  web;
        logic [31:0] di;
        int          cyc;
    } cs_ev_t;
    typedef struct {
        logic [31:0] d;
        logic        last;
        int          cyc;
    } rd_ev_t;

    cs_ev_t cs_q[$];
    rd_ev_t rd_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int cs_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.sram_cs) begin
                cs_q.push_back('{bus.sram_a, bus.sram_web, bus.sram_di, cyc});
                cs_total++;
            end
            if (bus.rdata_valid && bus.rdata_ready)
                rd_q.push_back('{bus.rdata, bus.rdata_last, cyc});
            if (bus.done)
                done_cnt++;
        end
    end

    logic [31:0] ref_mem [16384];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit               wr;
        logic [13:0]      addr;
        logic [LEN_W-1:0] len;
        logic [3:0]       wstrb;
        int               rmode;      // 0 ready held, 1 random ready, 2 ready low then released
        bit               use_base;
        logic [31:0]      base;
        int               exp_beats;
        logic [13:0]      exp_last_a;
    } vec_t;

    task automatic send_cmd(input bit wr, input logic [13:0] addr, input logic [LEN_W-1:0] len,
                            input logic [3:0] wstrb);
        int t = 0;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_wstrb = wstrb;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("cmd_ready_seen", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input bit rnd_valid);
        logic [31:0] wd [$];
        int cs0 = cs_q.size();
        int rd0 = rd_q.size();
        int dn0 = done_cnt;
        int n = int'(v.len) + 1;
        int i = 0;
        int t = 0;
        int got;
        bit fire;
        logic [13:0] ea;
        for (int k = 0; k < n; k++)
            wd.push_back(v.use_base ? v.base + 32'(k) : $urandom);
        send_cmd(v.wr, v.addr, v.len, v.wstrb);
        if (v.wr) begin
            while (i < n && t < 2000) begin
                bus.wdata       = wd[i];
                bus.wdata_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                fire = bus.wdata_valid && bus.wdata_ready;
                @(posedge clk); #1;
                t++;
                if (fire) i++;
            end
            bus.wdata_valid = 1'b0;
        end else begin
            while ((rd_q.size() - rd0) < n && t < 2000) begin
                case (v.rmode)
                    0:       bus.rdata_ready = 1'b1;
                    1:       bus.rdata_ready = ($urandom_range(0, 2) != 0);
                    default: bus.rdata_ready = (t >= 30);
                endcase
                if (v.rmode == 2 && t == 25) begin
                    check("stall_issue_count", 64'(cs_q.size() - cs0), 64'(DEPTH));
                    check("stall_cs_low", 64'(bus.sram_cs), 64'd0);
                end
                @(posedge clk); #1;
                t++;
            end
            bus.rdata_ready = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("beats", 64'(cs_q.size() - cs0), 64'(v.exp_beats));
        check("done_pulses", 64'(done_cnt - dn0), 64'd1);
        got = cs_q.size() - cs0;
        if (!v.wr && (rd_q.size() - rd0) < got) got = rd_q.size() - rd0;
        if (got > n) got = n;
        for (int k = 0; k < got; k++) begin
            ea = v.addr + 14'(k);
            if (v.wr) begin
                check("wr_beat", {cs_q[cs0+k].a, cs_q[cs0+k].web, cs_q[cs0+k].di},
                      {ea, ~v.wstrb, wd[k]});
                for (int b = 0; b < 4; b++)
                    if (v.wstrb[b]) ref_mem[ea][8*b +: 8] = wd[k][8*b +: 8];
            end else begin
                check("rd_beat", {cs_q[cs0+k].a, cs_q[cs0+k].web, rd_q[rd0+k].d, rd_q[rd0+k].last},
                      {ea, 4'hF, ref_mem[ea], (k == n - 1)});
            end
        end
        if (got == n) check("last_addr", 64'(cs_q[cs0+n-1].a), 64'(v.exp_last_a));
        if (!rnd_valid && got == n) begin
            if (v.wr)
                check("wr_back_to_back", 64'(cs_q[cs0+n-1].cyc - cs_q[cs0].cyc), 64'(n - 1));
            else if (v.rmode == 0) begin
                check("rd_latency", 64'(rd_q[rd0].cyc - cs_q[cs0].cyc), 64'd2);
                check("rd_back_to_back", 64'(rd_q[rd0+n-1].cyc - rd_q[rd0].cyc), 64'(n - 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        vec_t v;
        int cs0, dn0, t, cs_at_rst;

        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.cmd_wstrb   = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);

        //          wr    addr      len  wstrb rmode base?  base          beats last_a
        tbl[0] = '{1'b1, 14'h0010, 8'd3,  4'hF, 0, 1'b1, 32'h0000_00A0, 4,  14'h0013};
        tbl[1] = '{1'b0, 14'h0010, 8'd3,  4'hF, 0, 1'b0, 32'h0,         4,  14'h0013};
        tbl[2] = '{1'b1, 14'h3FFE, 8'd2,  4'h5, 0, 1'b1, 32'h1122_3344, 3,  14'h0000};
        tbl[3] = '{1'b0, 14'h3FFE, 8'd2,  4'hF, 0, 1'b0, 32'h0,         3,  14'h0000};
        tbl[4] = '{1'b1, 14'h0100, 8'd0,  4'h8, 0, 1'b1, 32'hDEAD_BEEF, 1,  14'h0100};
        tbl[5] = '{1'b0, 14'h0100, 8'd0,  4'hF, 0, 1'b0, 32'h0,         1,  14'h0100};
        tbl[6] = '{1'b0, 14'h0200, 8'd15, 4'hF, 2, 1'b0, 32'h0,         16, 14'h020F};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",   64'(bus.cmd_ready),   64'd1);
        check("rst_wdata_ready", 64'(bus.wdata_ready), 64'd0);
        check("rst_rdata",       {bus.rdata_valid, bus.rdata_last, bus.rdata}, 64'd0);
        check("rst_done",        64'(bus.done),        64'd0);
        check("rst_sram_ctl",    {bus.sram_cs, bus.sram_oe, bus.sram_web}, 64'h0F);
        check("rst_sram_a_di",   {bus.sram_a, bus.sram_di}, 64'd0);
`ifdef SRAM_BURST_MASTER_PERF_EN
        check("rst_perf", {perf_beats, perf_stall}, 64'd0);
`endif
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_cmd(tbl[k], 1'b0);
`ifdef SRAM_BURST_MASTER_PERF_EN
        check("perf_stall_nonzero", 64'(perf_stall != 0), 64'd1);
`endif

        for (int k = 0; k < 24; k++) begin
            v.wr       = bit'($urandom_range(0, 1));
            v.addr     = ($urandom_range(0, 3) == 0) ? 14'h3FFC + 14'($urandom_range(0, 3))
                                                     : 14'($urandom_range(0, 255));
            v.len      = LEN_W'($urandom_range(0, 9));
            v.wstrb    = 4'($urandom_range(0, 15));
            v.rmode    = 1;
            v.use_base = 1'b0;
            v.base     = '0;
            v.exp_beats  = int'(v.len) + 1;
            v.exp_last_a = v.addr + 14'(v.len);
            run_cmd(v, 1'b1);
        end

        // Reset in the middle of an 8-beat read.
        dn0 = done_cnt;
        cs0 = cs_q.size();
        send_cmd(1'b0, 14'h0040, 8'd7, 4'hF);
        bus.rdata_ready = 1'b1;
        t = 0;
        while ((cs_q.size() - cs0) < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("mid_reset_reached_beat2", 64'(cs_q.size() - cs0 >= 2), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_cmd_ready",   64'(bus.cmd_ready),   64'd1);
        check("arst_wdata_ready", 64'(bus.wdata_ready), 64'd0);
        check("arst_rdata",       {bus.rdata_valid, bus.rdata_last, bus.rdata}, 64'd0);
        check("arst_done",        64'(bus.done),        64'd0);
        check("arst_sram_ctl",    {bus.sram_cs, bus.sram_oe, bus.sram_web}, 64'h0F);
        check("arst_sram_a_di",   {bus.sram_a, bus.sram_di}, 64'd0);
        bus.rdata_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cs_at_rst = cs_total;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_done",     64'(done_cnt - dn0), 64'd0);
        check("arst_fifo_empty",  64'(bus.rdata_valid), 64'd0);
        v = '{1'b1, 14'h0040, 8'd1, 4'hF, 0, 1'b1, 32'h5555_0000, 2, 14'h0041};
        run_cmd(v, 1'b0);
        v = '{1'b0, 14'h0040, 8'd1, 4'hF, 0, 1'b0, 32'h0, 2, 14'h0041};
        run_cmd(v, 1'b0);
`ifdef SRAM_BURST_MASTER_PERF_EN
        check("perf_beats", 64'(perf_beats), 64'(cs_total - cs_at_rst));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
